// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: owns the RTC multiplexed address/data bus and drives the
// AD/CS/RD/WR strobes for N_CH requesters (time read, time set, alarm set, ...).
// Each transaction runs ADDR -> DATA -> GAP with programmable phase lengths.
// Every output is registered; output values are decoded from the next state.
//
// Build option: define RTC_BUS_FIXED_PRIO_EN to replace round-robin arbitration
// with fixed priority (lowest channel index wins, no rotating pointer).

module rtc_bus_sequencer #(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 8,
  parameter int unsigned T_ADDR = 4,
  parameter int unsigned T_DATA = 4,
  parameter int unsigned T_GAP  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_CH-1:0]   req,
  input  logic [N_CH-1:0]   we,
  input  logic [N_CH*AW-1:0] addr,
  input  logic [N_CH*DW-1:0] wdata,
  output logic [N_CH-1:0]   gnt,
  output logic [N_CH-1:0]   done,
  output logic [DW-1:0]     rdata,
  output logic              busy,
  output logic [DW-1:0]     ad_out,
  output logic              ad_oe,
  input  logic [DW-1:0]     ad_in,
  output logic              ad_n,
  output logic              cs_n,
  output logic              rd_n,
  output logic              wr_n
);

  // Longest phase decides the down-counter width; it counts from T-1 to 0.
  localparam int unsigned TMAX_AD = (T_ADDR > T_DATA) ? T_ADDR : T_DATA;
  localparam int unsigned TMAX    = (TMAX_AD > T_GAP) ? TMAX_AD : T_GAP;
  localparam int unsigned CW      = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int unsigned CHW     = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_CH-1:0]   sel_q, sel_d;    // one-hot owner of the current transaction
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;

  logic [N_CH-1:0]   gnt_q, gnt_d;
  logic [N_CH-1:0]   done_q, done_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic [DW-1:0]     ad_out_q, ad_out_d;
  logic              ad_oe_q, ad_oe_d;
  logic              ad_n_q, ad_n_d;
  logic              cs_n_q, cs_n_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;

  // Arbitration result for the current cycle
  logic              win_valid;
  logic [N_CH-1:0]   win_sel;
  logic              win_we;
  logic [AW-1:0]     win_addr;
  logic [DW-1:0]     win_wdata;

`ifndef RTC_BUS_FIXED_PRIO_EN
  logic [CHW-1:0]    ptr_q, ptr_d;
  logic [CHW-1:0]    win_idx;
`endif

`ifdef RTC_BUS_FIXED_PRIO_EN
  // Fixed priority: the lowest requesting index wins.
  always_comb begin
    win_valid = 1'b0;
    win_sel   = '0;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!win_valid && req[i]) begin
        win_valid  = 1'b1;
        win_sel[i] = 1'b1;
        win_we     = we[i];
        win_addr   = addr[i*AW +: AW];
        win_wdata  = wdata[i*DW +: DW];
      end
    end
  end
`else
  // Round-robin: first search indices at or above the pointer, then wrap to the rest.
  always_comb begin
    win_valid = 1'b0;
    win_sel   = '0;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    win_idx   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!win_valid && req[i] && (CHW'(i) >= ptr_q)) begin
        win_valid  = 1'b1;
        win_sel[i] = 1'b1;
        win_we     = we[i];
        win_addr   = addr[i*AW +: AW];
        win_wdata  = wdata[i*DW +: DW];
        win_idx    = CHW'(i);
      end
    end
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!win_valid && req[i]) begin
        win_valid  = 1'b1;
        win_sel[i] = 1'b1;
        win_we     = we[i];
        win_addr   = addr[i*AW +: AW];
        win_wdata  = wdata[i*DW +: DW];
        win_idx    = CHW'(i);
      end
    end
  end
`endif

  // Next-state logic: phase sequencing, transaction latching, gnt/done/rdata.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    gnt_d   = '0;
    done_d  = '0;
    rdata_d = rdata_q;
`ifndef RTC_BUS_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d = StAddr;
          cnt_d   = CW'(T_ADDR - 1);
          sel_d   = win_sel;
          we_d    = win_we;
          addr_d  = win_addr;
          wdata_d = win_wdata;
          gnt_d   = win_sel;
`ifndef RTC_BUS_FIXED_PRIO_EN
          ptr_d   = (win_idx == CHW'(N_CH - 1)) ? '0 : win_idx + CHW'(1);
`endif
        end
      end
      StAddr: begin
        if (cnt_q == '0) begin
          state_d = StData;
          cnt_d   = CW'(T_DATA - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          state_d = StGap;
          cnt_d   = CW'(T_GAP - 1);
          done_d  = sel_q;
          // Read data is taken on the edge that closes the last DATA cycle.
          if (!we_q) begin
            rdata_d = ad_in;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Bus/strobe values for the upcoming cycle, decoded from the next state so they
  // can be registered without a cycle of lag.
  always_comb begin
    ad_n_d   = 1'b1;
    cs_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = '0;
    busy_d   = (state_d != StIdle);
    unique case (state_d)
      StAddr: begin
        ad_n_d   = 1'b0;
        cs_n_d   = 1'b0;
        wr_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = DW'(addr_d);
      end
      StData: begin
        cs_n_d = 1'b0;
        if (we_d) begin
          wr_n_d   = 1'b0;
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_d;
        end else begin
          rd_n_d = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  // State, latched transaction and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      ad_out_q <= '0;
      ad_oe_q  <= 1'b0;
      ad_n_q   <= 1'b1;
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      ad_out_q <= ad_out_d;
      ad_oe_q  <= ad_oe_d;
      ad_n_q   <= ad_n_d;
      cs_n_q   <= cs_n_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
    end
  end

`ifndef RTC_BUS_FIXED_PRIO_EN
  // Round-robin pointer: next channel to be favoured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign rdata  = rdata_q;
  assign busy   = busy_q;
  assign ad_out = ad_out_q;
  assign ad_oe  = ad_oe_q;
  assign ad_n   = ad_n_q;
  assign cs_n   = cs_n_q;
  assign rd_n   = rd_n_q;
  assign wr_n   = wr_n_q;

endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Parametrised successor to the read/write control-signal selector: instead of a static mux between a read and a write control source, it owns the RTC multiplexed address/data bus and generates the AD/CS/RD/WR strobes itself with programmable phase lengths. It arbitrates among N_CH requesters, each of which may issue reads or writes. It sits between the controller FSMs (time read, time set, alarm set) and the RTC chip pins.

## Interface
- N_CH, 2, number of requester channels (≥1)
- AW, 8, address width (≤ DW)
- DW, 8, data width of the AD bus
- T_ADDR, 4, address-phase length in cycles (≥1)
- T_DATA, 4, data-phase length in cycles (≥1)
- T_GAP, 2, idle recovery between transactions in cycles (≥1)

- clk  in  1  system clock; everything is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  N_CH  per-channel request; hold until gnt.
- we  in  N_CH  1 = write, 0 = read; valid while req is high.
- addr  in  N_CH*AW  channel i occupies bits [i*AW +: AW].
- wdata  in  N_CH*DW  channel i occupies bits [i*DW +: DW].
- gnt  out  N_CH  one-cycle acceptance pulse; one-hot or zero.
- done  out  N_CH  one-cycle completion pulse; one-hot or zero.
- rdata  out  DW  read data; valid when done pulses for a read, held until next read.
- busy  out  1  high from ADDR through GAP.
- ad_out  out  DW  value driven on the AD bus.
- ad_oe  out  1  AD bus output enable.
- ad_in  in  DW  AD bus input.
- ad_n, cs_n, rd_n, wr_n  out  1 each  RTC strobes, active-low.

## Operation
- FSM states: IDLE, ADDR, DATA, GAP. Down-counter sized for max(T_ADDR, T_DATA, T_GAP).
- IDLE: all strobes high, ad_oe=0. If any req is high, choose the winner i, latch addr_i, wdata_i, we_i, go to ADDR, and pulse gnt[i] in the first ADDR cycle.
- ADDR, T_ADDR cycles: ad_n=0, cs_n=0, wr_n=0, rd_n=1, ad_oe=1, ad_out=zero-extended address.
- DATA, T_DATA cycles: ad_n=1, cs_n=0.
  - Write: wr_n=0, ad_oe=1, ad_out=wdata.
  - Read: rd_n=0, ad_oe=0. ad_in is captured into rdata on the clock edge that ends the last DATA cycle.
- GAP, T_GAP cycles: all strobes high, ad_oe=0. done[i] pulses in the first GAP cycle. Return to IDLE after the last GAP cycle.
- Arbitration is round-robin. The search starts at pointer p (reset value 0). After a grant to channel i, p becomes (i+1) mod N_CH.
- Requests are sampled only in IDLE. Dropping req after gnt has no effect. If req is still high in IDLE after done, it is a new transaction.
- The latched we/addr/wdata are immune to input changes after acceptance.
- Reset values: state=IDLE, ad_n=cs_n=rd_n=wr_n=1, ad_oe=0, ad_out=0, gnt=0, done=0, rdata=0, busy=0, p=0.
- Reset mid-transaction: strobes deassert immediately (asynchronous), no done is issued, and the aborted transaction is lost.

## Timing
- Req sampled in IDLE at edge k: ADDR covers cycles k+1..k+T_ADDR, with gnt at cycle k+1.
- DATA covers cycles k+T_ADDR+1..k+T_ADDR+T_DATA.
- done fires at cycle k+T_ADDR+T_DATA+1.
- IDLE resumes at cycle k+T_ADDR+T_DATA+T_GAP+1.
- Back-to-back transaction period is T_ADDR+T_DATA+T_GAP+1 cycles; with defaults, 11 cycles.
- All outputs are registered. No combinational path from req or ad_in to any output.
- cs_n is held low continuously across the ADDR→DATA boundary; ad_n rises on the same edge that the data value appears.

## Configuration
- RTC_BUS_FIXED_PRIO_EN defined: fixed priority, lowest index wins, and the pointer p is removed.
- RTC_BUS_FIXED_PRIO_EN undefined (default): round-robin as described above.

## Test plan
- Single write, ch0, addr=0x21, wdata=0x45: ad_n/cs_n/wr_n low for 4 cycles with ad_out=0x21. Then ad_n high, wr_n low 4 cycles with ad_out=0x45. done[0] at cycle 9 after sampling; rd_n never low.
- Single read, ch1, addr=0x24, ad_in=0x59 during DATA: rd_n low 4 cycles with ad_oe=0. rdata=0x59 when done[1] pulses; rdata holds 0x59 afterwards.
- ch0 and ch1 request continuously: grants alternate 0,1,0,1 at an 11-cycle period. With RTC_BUS_FIXED_PRIO_EN, ch0 is granted every time.
- addr/wdata/we changed and req dropped right after gnt: the bus still shows the originally latched values and done still fires.
- reset_n asserted during DATA of a write: wr_n/cs_n go high without a clock edge, no done. After release, the first req starts in ADDR with p=0.
- Non-default configuration (N_CH=3, T_ADDR=1, T_DATA=1, T_GAP=1): period is 4 cycles and round-robin order is 0→1→2→0 with all three requesting.
